// File: rtl/pmips_pkg.sv
// pmips_pkg: shared constants for the 16-bit pmips core and its instruction
// memory. Holds the word width, the NOP encoding returned for out-of-range
// fetches, the program-loader state encoding and the opcode constants used
// by the core decoder.
package pmips_pkg;

  localparam int          WORD_W = 16;
  localparam logic [15:0] NOP    = 16'h0000;

  // Program loader states: idle, or assembling bytes into a word.
  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_BYTE = 1'b1
  } ld_state_t;

  // Opcode field (instr[15:12]) values shared with the core decoder.
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] OP_LUI   = 4'h7;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: byte-to-word assembler for the program load port.
// Bytes arrive little-endian within a word; each full word (or the partial
// word closed by ld_last, zero-padded) is emitted as a one-cycle write.
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   ld_valid/ld_byte/     byte stream in; ld_last marks the final byte
//   ld_last
//   ld_ready              always 1 (one byte per cycle)
//   ld_busy               a load is in progress (state != LD_IDLE)
//   ld_done, ld_ovf       sticky completion / overflow flags
//   wr_en/wr_addr/wr_data write strobe into the instruction array
module imem_loader
  import pmips_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_done,
  output logic             ld_ovf,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  localparam int LANES = WIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = AW + 1;  // ptr must be able to hold DEPTH itself

  ld_state_t        state_reg, state_next;
  logic [LW-1:0]    lane_reg, lane_next;
  logic [PW-1:0]    ptr_reg, ptr_next;
  logic [WIDTH-1:0] buf_reg, buf_next;
  logic             done_reg, done_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] merged;
  logic             full;

  // Word with the incoming byte in the current lane, earlier lanes from the
  // buffer and later lanes zero (the padding used when ld_last closes early).
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = (LW'(gi) == lane_reg) ? ld_byte :
                                 (LW'(gi) <  lane_reg) ? buf_reg[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign full = (ptr_reg == PW'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= LD_IDLE;
      lane_reg  <= '0;
      ptr_reg   <= '0;
      buf_reg   <= '0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      ptr_reg   <= ptr_next;
      buf_reg   <= buf_next;
      done_reg  <= done_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    ptr_next   = ptr_reg;
    buf_next   = buf_reg;
    done_next  = done_reg;
    ovf_next   = ovf_reg;
    wr_en      = 1'b0;
    if (ld_valid) begin
      // First byte of a new load clears the previous load's flags; ptr and
      // lane are already 0 because every load ends by returning them to 0.
      if (state_reg == LD_IDLE) begin
        done_next = 1'b0;
        ovf_next  = 1'b0;
      end
      if (full) ovf_next = 1'b1;
      buf_next = merged;
      if (ld_last) begin
        wr_en      = !full;
        state_next = LD_IDLE;
        lane_next  = '0;
        ptr_next   = '0;
        buf_next   = '0;
        done_next  = 1'b1;
      end else if (lane_reg == LW'(LANES - 1)) begin
        wr_en      = !full;
        state_next = LD_BYTE;
        lane_next  = '0;
        buf_next   = '0;
        if (!full) ptr_next = ptr_reg + PW'(1);
      end else begin
        state_next = LD_BYTE;
        lane_next  = lane_reg + LW'(1);
      end
    end
  end

  assign ld_ready = 1'b1;
  assign ld_busy  = (state_reg != LD_IDLE);
  assign ld_done  = done_reg;
  assign ld_ovf   = ovf_reg;
  assign wr_addr  = ptr_reg[AW-1:0];
  assign wr_data  = merged;

endmodule

// File: rtl/prog_imem.sv
// prog_imem: loadable instruction memory for the 16-bit pmips core.
// A program is streamed in byte-wise through imem_loader; the core fetches
// with a one-cycle registered read. Fetches are dropped while a load is busy.
// Word indices >= DEPTH read as NOP. The array is never reset.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, perr output).
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   iaddr, ifetch         byte fetch address (bit 0 ignored), fetch request
//   idata, ivalid         registered instruction word and its valid flag
//   ld_valid/ld_byte/     program load byte stream
//   ld_last, ld_ready
//   ld_busy, ld_done,     loader status
//   ld_ovf
//   perr                  fetch parity error (0 when parity disabled)
module prog_imem
  import pmips_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      iaddr,
  input  logic             ifetch,
  output logic [WIDTH-1:0] idata,
  output logic             ivalid,
  input  logic             ld_valid,
  input  logic [7:0]       ld_byte,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_done,
  output logic             ld_ovf,
  output logic             perr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] idata_reg;
  logic             ivalid_reg;
  logic [14:0]      word_idx;
  logic [AW-1:0]    rd_addr;
  logic             in_range;
  logic             fetch_go;
  logic             unused_addr_lsb;

  imem_loader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_loader (
    .clock    (clock),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_ovf   (ld_ovf),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  // Range check uses the full word index so that high address bits beyond
  // the array alias to NOP instead of wrapping onto real words.
  assign word_idx        = iaddr[15:1];
  assign rd_addr         = iaddr[AW:1];
  assign in_range        = (word_idx < 15'(DEPTH));
  assign fetch_go        = ifetch && !ld_busy;
  assign unused_addr_lsb = iaddr[0];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idata_reg  <= '0;
      ivalid_reg <= 1'b0;
    end else if (fetch_go) begin
      ivalid_reg <= 1'b1;
      idata_reg  <= in_range ? mem[rd_addr] : WIDTH'(NOP);
    end else begin
      ivalid_reg <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_reg;

  // Stored bit makes word+parity an even number of ones.
  always_ff @(posedge clock) begin
    if (wr_en) par_mem[wr_addr] <= ^wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perr_reg <= 1'b0;
    end else if (fetch_go && in_range) begin
      perr_reg <= (^mem[rd_addr]) ^ par_mem[rd_addr];
    end else begin
      perr_reg <= 1'b0;
    end
  end

  assign perr = perr_reg;
`else
  assign perr = 1'b0;
`endif

  assign idata  = idata_reg;
  assign ivalid = ivalid_reg;

endmodule

// File: tb/tb_prog_imem.sv
// tb_prog_imem: directed self-checking bench for prog_imem.
// Instance dut uses default sizing (DEPTH=32); instance dq uses DEPTH=4 for
// the overflow case. Inputs change and outputs are sampled on falling edges.
module tb_prog_imem;

  logic        clock;
  logic        reset;
  logic [15:0] iaddr;
  logic        ifetch;
  logic [15:0] idata;
  logic        ivalid;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready, ld_busy, ld_done, ld_ovf, perr;

  logic [15:0] q_iaddr;
  logic        q_ifetch;
  logic [15:0] q_idata;
  logic        q_ivalid;
  logic        q_ld_valid;
  logic [7:0]  q_ld_byte;
  logic        q_ld_last;
  logic        q_ld_ready, q_ld_busy, q_ld_done, q_ld_ovf, q_perr;

  int n_cmp = 0;
  int n_err = 0;

  prog_imem dut (
    .clock (clock), .reset (reset),
    .iaddr (iaddr), .ifetch (ifetch), .idata (idata), .ivalid (ivalid),
    .ld_valid (ld_valid), .ld_byte (ld_byte), .ld_last (ld_last),
    .ld_ready (ld_ready), .ld_busy (ld_busy), .ld_done (ld_done),
    .ld_ovf (ld_ovf), .perr (perr)
  );

  prog_imem #(.WIDTH(16), .DEPTH(4), .AW(2)) dq (
    .clock (clock), .reset (reset),
    .iaddr (q_iaddr), .ifetch (q_ifetch), .idata (q_idata), .ivalid (q_ivalid),
    .ld_valid (q_ld_valid), .ld_byte (q_ld_byte), .ld_last (q_ld_last),
    .ld_ready (q_ld_ready), .ld_busy (q_ld_busy), .ld_done (q_ld_done),
    .ld_ovf (q_ld_ovf), .perr (q_perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One byte on the default instance, one cycle.
  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic qsend(input logic [7:0] b, input logic last);
    q_ld_valid = 1'b1; q_ld_byte = b; q_ld_last = last;
    step();
    q_ld_valid = 1'b0; q_ld_last = 1'b0;
  endtask

  // Single fetch on the default instance, sampled after the capturing edge.
  task automatic fetch(input logic [15:0] a);
    ifetch = 1'b1; iaddr = a;
    step();
    ifetch = 1'b0;
  endtask

  task automatic qfetch(input logic [15:0] a);
    q_ifetch = 1'b1; q_iaddr = a;
    step();
    q_ifetch = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    iaddr = '0; ifetch = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
    q_iaddr = '0; q_ifetch = 1'b0; q_ld_valid = 1'b0; q_ld_byte = '0; q_ld_last = 1'b0;
    step();
    step();
    check("rst_idata",    {16'h0, idata}, 32'h0);
    check("rst_ivalid",   {31'h0, ivalid}, 32'h0);
    check("rst_ld_ready", {31'h0, ld_ready}, 32'h1);
    check("rst_ld_busy",  {31'h0, ld_busy}, 32'h0);
    check("rst_ld_done",  {31'h0, ld_done}, 32'h0);
    check("rst_ld_ovf",   {31'h0, ld_ovf}, 32'h0);
    check("rst_perr",     {31'h0, perr}, 32'h0);
    reset = 1'b0;
    step();

    // Four-byte program: words 6103, 0043.
    send(8'h03, 1'b0);
    check("load_busy_b0", {31'h0, ld_busy}, 32'h1);
    send(8'h61, 1'b0);
    send(8'h43, 1'b0);
    send(8'h00, 1'b1);
    check("load_done",    {31'h0, ld_done}, 32'h1);
    check("load_idle",    {31'h0, ld_busy}, 32'h0);
    check("load_no_ovf",  {31'h0, ld_ovf}, 32'h0);
    fetch(16'h0000);
    check("f0_ivalid", {31'h0, ivalid}, 32'h1);
    check("f0_idata",  {16'h0, idata}, 32'h6103);
    fetch(16'h0002);
    check("f2_idata",  {16'h0, idata}, 32'h0043);
    step();
    check("nofetch_ivalid", {31'h0, ivalid}, 32'h0);
    check("nofetch_hold",   {16'h0, idata}, 32'h0043);
    fetch(16'h0003);
    check("f3_lsb_ignored", {16'h0, idata}, 32'h0043);

    // Out-of-range word index reads as NOP but still valid.
    fetch(16'h0040);
    check("oor_ivalid", {31'h0, ivalid}, 32'h1);
    check("oor_idata",  {16'h0, idata}, 32'h0000);

    // Single odd byte closes a word with zero padding.
    send(8'h7D, 1'b1);
    check("odd_done", {31'h0, ld_done}, 32'h1);
    fetch(16'h0000);
    check("odd_w0",   {16'h0, idata}, 32'h007D);
    fetch(16'h0002);
    check("odd_w1_kept", {16'h0, idata}, 32'h0043);

    // Reset leaves the array intact.
    reset = 1'b1;
    step();
    check("rst2_idata", {16'h0, idata}, 32'h0);
    reset = 1'b0;
    fetch(16'h0000);
    check("rst2_ivalid", {31'h0, ivalid}, 32'h1);
    check("rst2_w0",     {16'h0, idata}, 32'h007D);
    check("rst2_done",   {31'h0, ld_done}, 32'h0);

    // Fetch during load is dropped; reset mid-load discards partial word.
    send(8'hA1, 1'b0);
    ifetch = 1'b1; iaddr = 16'h0000;
    send(8'hB2, 1'b0);
    check("busy_fetch_ivalid1", {31'h0, ivalid}, 32'h0);
    check("busy_fetch_hold",    {16'h0, idata}, 32'h007D);
    send(8'hC3, 1'b0);
    check("busy_fetch_ivalid2", {31'h0, ivalid}, 32'h0);
    check("busy_3b",            {31'h0, ld_busy}, 32'h1);
    ifetch = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'h0, ld_busy}, 32'h0);
    check("abort_done", {31'h0, ld_done}, 32'h0);
    fetch(16'h0000);
    check("abort_w0_new", {16'h0, idata}, 32'hB2A1);
    fetch(16'h0002);
    check("abort_w1_kept", {16'h0, idata}, 32'h0043);

    // DEPTH=4 instance: ten bytes overflow by one word.
    for (int i = 0; i < 8; i++) qsend(8'(i), 1'b0);
    check("q_no_ovf_at_cap", {31'h0, q_ld_ovf}, 32'h0);
    qsend(8'h08, 1'b0);
    check("q_ovf_set", {31'h0, q_ld_ovf}, 32'h1);
    qsend(8'h09, 1'b1);
    check("q_done", {31'h0, q_ld_done}, 32'h1);
    check("q_ovf",  {31'h0, q_ld_ovf}, 32'h1);
    qfetch(16'h0000);
    check("q_w0", {16'h0, q_idata}, 32'h0100);
    qfetch(16'h0002);
    check("q_w1", {16'h0, q_idata}, 32'h0302);
    qfetch(16'h0004);
    check("q_w2", {16'h0, q_idata}, 32'h0504);
    qfetch(16'h0006);
    check("q_w3", {16'h0, q_idata}, 32'h0706);
    qfetch(16'h0008);
    check("q_oor_ivalid", {31'h0, q_ivalid}, 32'h1);
    check("q_oor_idata",  {16'h0, q_idata}, 32'h0000);

    // A new load clears the sticky overflow flag and restarts at word 0.
    qsend(8'h55, 1'b1);
    check("q_reload_ovf",  {31'h0, q_ld_ovf}, 32'h0);
    check("q_reload_done", {31'h0, q_ld_done}, 32'h1);
    qfetch(16'h0000);
    check("q_reload_w0", {16'h0, q_idata}, 32'h0055);

`ifdef IMEM_PARITY_EN
    fetch(16'h0000);
    check("par_clean", {31'h0, perr}, 32'h0);
    dut.mem[1][0] = ~dut.mem[1][0];
    fetch(16'h0002);
    check("par_err_ivalid", {31'h0, ivalid}, 32'h1);
    check("par_err",        {31'h0, perr}, 32'h1);
    fetch(16'h0040);
    check("par_oor", {31'h0, perr}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
